// File: rtl/instruction_fetch_arbiter.sv
// rtl/instruction_fetch_arbiter.sv - arbitrates a shared instruction ROM between fetch and debug reads
module instruction_fetch_arbiter #(
    parameter logic [15:0] RESET_PC     = 16'h0001,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        sync_rst,
    input  logic        Run,
    input  logic        RedirectValid,
    input  logic [15:0] RedirectAddress,
    output logic        FetchValid,
    input  logic        FetchReady,
    output logic [15:0] FetchInstruction,
    output logic [15:0] FetchPC,
    input  logic        DebugReq,
    input  logic [15:0] DebugAddress,
    output logic        DebugAck,
    output logic [15:0] DebugData,
    output logic [15:0] RomAddress,
    input  logic [15:0] RomData
);

    localparam logic [2:0] LP_LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_DEBUG
    } owner_t;

    logic [15:0] r_pc;
    logic        r_fetch_valid;
    logic [15:0] r_fetch_instr;
    logic [15:0] r_fetch_pc;
    logic        r_debug_ack;
    logic [15:0] r_debug_data;
    logic [2:0]  r_starve_cnt;

    logic        w_free;
    logic        w_debug_req;
    logic        w_forced;
    logic        w_fetch_grant;
    logic        w_debug_grant;
    owner_t      w_owner;

    // A request is only live while its previous ack is not being presented,
    // so the one-cycle ack pulse never triggers a second access.
    assign w_free      = !r_fetch_valid || FetchReady;
    assign w_debug_req = DebugReq && !r_debug_ack;
    assign w_forced    = w_debug_req && (r_starve_cnt == LP_LIMIT);

    // Grant resolution: redirect blocks fetch, forced debug blocks fetch,
    // otherwise fetch wins over a normal debug request.
    always_comb begin
        w_fetch_grant = 1'b0;
        w_debug_grant = 1'b0;
        w_owner       = OWN_NONE;
        if (Run && !RedirectValid && w_free && !w_forced) begin
            w_fetch_grant = 1'b1;
        end
        if (w_debug_req && !w_fetch_grant) begin
            w_debug_grant = 1'b1;
        end
        if (w_debug_grant) begin
            w_owner = OWN_DEBUG;
        end else if (w_fetch_grant) begin
            w_owner = OWN_FETCH;
        end
    end

    assign RomAddress = (w_owner == OWN_DEBUG) ? DebugAddress : r_pc;

    // Debug read port: single-cycle access, ack pulse plus starvation counter.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_debug_ack  <= 1'b0;
            r_debug_data <= 16'h0000;
            r_starve_cnt <= 3'd0;
        end else begin
            r_debug_ack <= w_debug_grant;
            if (w_debug_grant) begin
                r_debug_data <= RomData;
            end
            if (w_debug_grant || !DebugReq) begin
                r_starve_cnt <= 3'd0;
            end else if (w_debug_req && (r_starve_cnt != LP_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 3'd1;
            end
        end
    end

    // Fetch path: PC and the one-entry output register toward decode.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_fetch_instr <= 16'h0000;
            r_fetch_pc    <= 16'h0000;
        end else if (RedirectValid) begin
            r_pc          <= RedirectAddress;
            r_fetch_valid <= 1'b0;
        end else if (w_fetch_grant) begin
            r_fetch_instr <= RomData;
            r_fetch_pc    <= r_pc;
            r_fetch_valid <= 1'b1;
            r_pc          <= r_pc + 16'd1;
        end else if (w_free) begin
            r_fetch_valid <= 1'b0;
        end
    end

    assign FetchValid       = r_fetch_valid;
    assign FetchInstruction = r_fetch_instr;
    assign FetchPC          = r_fetch_pc;
    assign DebugAck         = r_debug_ack;
    assign DebugData        = r_debug_data;

endmodule

// File: tb/tb_instruction_fetch_arbiter.sv
// tb/tb_instruction_fetch_arbiter.sv - directed self-checking bench for instruction_fetch_arbiter
module tb_instruction_fetch_arbiter;

    logic        clk;
    logic        sync_rst;
    logic        Run;
    logic        RedirectValid;
    logic [15:0] RedirectAddress;
    logic        FetchValid;
    logic        FetchReady;
    logic [15:0] FetchInstruction;
    logic [15:0] FetchPC;
    logic        DebugReq;
    logic [15:0] DebugAddress;
    logic        DebugAck;
    logic [15:0] DebugData;
    logic [15:0] RomAddress;
    logic [15:0] RomData;

    int checks;
    int failures;

    instruction_fetch_arbiter #(
        .RESET_PC    (16'h0001),
        .STARVE_LIMIT(4)
    ) dut (
        .clk             (clk),
        .sync_rst        (sync_rst),
        .Run             (Run),
        .RedirectValid   (RedirectValid),
        .RedirectAddress (RedirectAddress),
        .FetchValid      (FetchValid),
        .FetchReady      (FetchReady),
        .FetchInstruction(FetchInstruction),
        .FetchPC         (FetchPC),
        .DebugReq        (DebugReq),
        .DebugAddress    (DebugAddress),
        .DebugAck        (DebugAck),
        .DebugData       (DebugData),
        .RomAddress      (RomAddress),
        .RomData         (RomData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: three fixed words, everything else a simple address hash.
    function automatic logic [15:0] rom_word(input logic [15:0] a);
        case (a)
            16'h0001: rom_word = 16'hB00E;
            16'h000F: rom_word = 16'hCD07;
            16'h0010: rom_word = 16'hCC0B;
            default:  rom_word = a ^ 16'h3C00;
        endcase
    endfunction

    always_comb RomData = rom_word(RomAddress);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sync_rst = 1'b1;
        step();
        step();
        if (FetchValid !== 1'b0) begin $display("FAIL reset_fv got=%0h exp=0", FetchValid); failures++; end
        checks++;
        if (FetchPC !== 16'h0000) begin $display("FAIL reset_fpc got=%h exp=0000", FetchPC); failures++; end
        checks++;
        if (FetchInstruction !== 16'h0000) begin $display("FAIL reset_fi got=%h exp=0000", FetchInstruction); failures++; end
        checks++;
        if (DebugAck !== 1'b0 || DebugData !== 16'h0000) begin
            $display("FAIL reset_dbg got ack=%0h data=%h exp ack=0 data=0000", DebugAck, DebugData); failures++;
        end
        checks++;
        if (RomAddress !== 16'h0001) begin $display("FAIL reset_pc got=%h exp=0001", RomAddress); failures++; end
        checks++;
        sync_rst = 1'b0;
    endtask

    task automatic test_sequential();
        Run = 1'b1;
        FetchReady = 1'b1;
        step();
        if (FetchValid !== 1'b1 || FetchPC !== 16'h0001 || FetchInstruction !== 16'hB00E) begin
            $display("FAIL seq_first got v=%0h pc=%h ins=%h exp v=1 pc=0001 ins=b00e", FetchValid, FetchPC, FetchInstruction);
            failures++;
        end
        checks++;
        for (int k = 2; k <= 3; k++) begin
            step();
            if (FetchValid !== 1'b1 || FetchPC !== 16'(k) || FetchInstruction !== rom_word(16'(k))) begin
                $display("FAIL seq_pc%0d got v=%0h pc=%h ins=%h exp pc=%h ins=%h", k, FetchValid, FetchPC,
                         FetchInstruction, 16'(k), rom_word(16'(k)));
                failures++;
            end
            checks++;
        end
    endtask

    task automatic test_backpressure();
        FetchReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (FetchValid !== 1'b1 || FetchPC !== 16'h0003 || FetchInstruction !== rom_word(16'h0003)
                || RomAddress !== 16'h0004) begin
                $display("FAIL stall_%0d got v=%0h pc=%h ins=%h rom=%h exp v=1 pc=0003 ins=%h rom=0004", k,
                         FetchValid, FetchPC, FetchInstruction, RomAddress, rom_word(16'h0003));
                failures++;
            end
            checks++;
        end
        FetchReady = 1'b1;
        step();
        if (FetchValid !== 1'b1 || FetchPC !== 16'h0004) begin
            $display("FAIL stall_release got v=%0h pc=%h exp v=1 pc=0004", FetchValid, FetchPC); failures++;
        end
        checks++;
    endtask

    task automatic test_redirect();
        RedirectValid = 1'b1;
        RedirectAddress = 16'h000F;
        step();
        RedirectValid = 1'b0;
        if (FetchValid !== 1'b0) begin $display("FAIL redir_flush got v=%0h exp 0", FetchValid); failures++; end
        checks++;
        step();
        if (FetchValid !== 1'b1 || FetchPC !== 16'h000F || FetchInstruction !== 16'hCD07) begin
            $display("FAIL redir_target got v=%0h pc=%h ins=%h exp pc=000f ins=cd07", FetchValid, FetchPC, FetchInstruction);
            failures++;
        end
        checks++;
        step();
        if (FetchValid !== 1'b1 || FetchPC !== 16'h0010 || FetchInstruction !== 16'hCC0B) begin
            $display("FAIL redir_next got v=%0h pc=%h ins=%h exp pc=0010 ins=cc0b", FetchValid, FetchPC, FetchInstruction);
            failures++;
        end
        checks++;
    endtask

    task automatic test_debug_starve();
        logic [15:0] prev_pc;
        int          skips;
        int          ack_cycle;
        prev_pc = 16'h0010;
        skips = 0;
        ack_cycle = 0;
        DebugReq = 1'b1;
        DebugAddress = 16'h0001;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (FetchValid === 1'b1) begin
                if (FetchPC !== prev_pc + 16'd1) begin
                    $display("FAIL starve_seq got pc=%h exp=%h", FetchPC, prev_pc + 16'd1); failures++;
                end
                checks++;
                prev_pc = FetchPC;
            end else begin
                skips++;
            end
            if (DebugAck === 1'b1) begin
                ack_cycle = i;
                break;
            end
        end
        DebugReq = 1'b0;
        if (ack_cycle != 5) begin $display("FAIL starve_latency got=%0d exp=5", ack_cycle); failures++; end
        checks++;
        if (DebugData !== 16'hB00E) begin $display("FAIL starve_data got=%h exp=b00e", DebugData); failures++; end
        checks++;
        if (skips != 1) begin $display("FAIL starve_skips got=%0d exp=1", skips); failures++; end
        checks++;
        step();
        if (DebugAck !== 1'b0 || FetchValid !== 1'b1 || FetchPC !== prev_pc + 16'd1) begin
            $display("FAIL starve_after got ack=%0h v=%0h pc=%h exp ack=0 v=1 pc=%h", DebugAck, FetchValid,
                     FetchPC, prev_pc + 16'd1);
            failures++;
        end
        checks++;
    endtask

    task automatic test_halted_debug();
        Run = 1'b0;
        FetchReady = 1'b0;
        step();
        if (FetchValid !== 1'b1 || FetchPC !== 16'h0015) begin
            $display("FAIL halt_hold got v=%0h pc=%h exp v=1 pc=0015", FetchValid, FetchPC); failures++;
        end
        checks++;
        FetchReady = 1'b1;
        DebugReq = 1'b1;
        DebugAddress = 16'h0010;
        step();
        if (DebugAck !== 1'b1 || DebugData !== 16'hCC0B) begin
            $display("FAIL halt_dbg got ack=%0h data=%h exp ack=1 data=cc0b", DebugAck, DebugData); failures++;
        end
        checks++;
        if (FetchValid !== 1'b0 || RomAddress !== 16'h0016) begin
            $display("FAIL halt_nofetch got v=%0h rom=%h exp v=0 rom=0016", FetchValid, RomAddress); failures++;
        end
        checks++;
        DebugReq = 1'b0;
        step();
        if (DebugAck !== 1'b0) begin $display("FAIL halt_ackpulse got=%0h exp=0", DebugAck); failures++; end
        checks++;
    endtask

    task automatic test_wrap();
        Run = 1'b1;
        RedirectValid = 1'b1;
        RedirectAddress = 16'hFFFF;
        step();
        RedirectValid = 1'b0;
        step();
        if (FetchValid !== 1'b1 || FetchPC !== 16'hFFFF || FetchInstruction !== rom_word(16'hFFFF)) begin
            $display("FAIL wrap_ffff got v=%0h pc=%h ins=%h exp pc=ffff ins=%h", FetchValid, FetchPC,
                     FetchInstruction, rom_word(16'hFFFF));
            failures++;
        end
        checks++;
        step();
        if (FetchValid !== 1'b1 || FetchPC !== 16'h0000 || FetchInstruction !== rom_word(16'h0000)) begin
            $display("FAIL wrap_0000 got v=%0h pc=%h ins=%h exp pc=0000 ins=%h", FetchValid, FetchPC,
                     FetchInstruction, rom_word(16'h0000));
            failures++;
        end
        checks++;
    endtask

    task automatic test_reset_mid_debug();
        DebugReq = 1'b1;
        DebugAddress = 16'h0005;
        step();
        step();
        if (DebugAck !== 1'b0) begin $display("FAIL rstdbg_pending got ack=%0h exp=0", DebugAck); failures++; end
        checks++;
        sync_rst = 1'b1;
        step();
        if (DebugAck !== 1'b0 || FetchValid !== 1'b0) begin
            $display("FAIL rstdbg_in_reset got ack=%0h v=%0h exp ack=0 v=0", DebugAck, FetchValid); failures++;
        end
        checks++;
        sync_rst = 1'b0;
        DebugReq = 1'b0;
        Run = 1'b0;
        step();
        if (DebugAck !== 1'b0 || RomAddress !== 16'h0001) begin
            $display("FAIL rstdbg_after got ack=%0h rom=%h exp ack=0 rom=0001", DebugAck, RomAddress); failures++;
        end
        checks++;
        Run = 1'b1;
        step();
        if (FetchValid !== 1'b1 || FetchPC !== 16'h0001 || FetchInstruction !== 16'hB00E) begin
            $display("FAIL rstdbg_refetch got v=%0h pc=%h ins=%h exp pc=0001 ins=b00e", FetchValid, FetchPC,
                     FetchInstruction);
            failures++;
        end
        checks++;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        sync_rst = 1'b1;
        Run = 1'b0;
        RedirectValid = 1'b0;
        RedirectAddress = 16'h0000;
        FetchReady = 1'b0;
        DebugReq = 1'b0;
        DebugAddress = 16'h0000;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_debug_starve();
        test_halted_debug();
        test_wrap();
        test_reset_mid_debug();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_arbiter.md
INSTRUCTION_FETCH_ARBITER -- requirements
Module: instruction_fetch_arbiter

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0001: fetch address loaded on reset.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4: consecutive ungranted debug-request cycles before debug is forced (range 1-7).
REQ-003 The block SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 The block SHALL have port sync_rst, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port Run, input, 1: 1 = fetch enabled, 0 = fetch halted.
REQ-006 The block SHALL have ports RedirectValid, input, 1, and RedirectAddress, input, 16: call/branch target from the core.
REQ-007 The block SHALL have ports FetchValid, output, 1; FetchReady, input, 1; FetchInstruction, output, 16; FetchPC, output, 16: the instruction handshake to decode.
REQ-008 The block SHALL have ports DebugReq, input, 1; DebugAddress, input, 16; DebugAck, output, 1; DebugData, output, 16: the debug/loader read port.
REQ-009 The block SHALL have ports RomAddress, output, 16, and RomData, input, 16: the shared combinational instruction ROM port; RomData is valid in the same cycle.

Function
REQ-010 The block SHALL hold a 16-bit PC, a one-entry output register (FetchValid/FetchInstruction/FetchPC), a registered DebugData/DebugAck, and a 3-bit starvation counter.
REQ-011 The ROM owner each cycle SHALL be exactly one of FETCH, DEBUG, NONE; RomAddress = PC for FETCH, DebugAddress for DEBUG, PC for NONE.
REQ-012 The output register is "free" when FetchValid=0 or (FetchValid=1 and FetchReady=1).
REQ-013 Priority order SHALL be: RedirectValid, forced debug (counter = STARVE_LIMIT), fetch, normal debug.
REQ-014 With RedirectValid=1, the next state SHALL be PC <= RedirectAddress and FetchValid <= 0 (output entry flushed, even if FetchReady=1), and no fetch SHALL occur that cycle; debug MAY be granted that cycle.
REQ-015 Fetch SHALL be granted when Run=1, RedirectValid=0, the output register is free, and debug is not forced. On grant: FetchInstruction <= RomData, FetchPC <= PC, FetchValid <= 1, PC <= PC+1.
REQ-016 PC increment SHALL wrap modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-017 When the output register is free and not refilled, FetchValid SHALL go to 0 next cycle; when FetchValid=1 and FetchReady=0, all Fetch* outputs SHALL hold stable.
REQ-018 Normal debug SHALL be granted when DebugReq=1, DebugAck=0, and fetch is not granted.
REQ-019 On any debug grant: DebugData <= RomData, DebugAck <= 1 for exactly one cycle (single-cycle access latency).
REQ-020 DebugReq SHALL be ignored in the cycle DebugAck=1; the requester holds DebugReq and DebugAddress stable until DebugAck.
REQ-021 The starvation counter SHALL increment (saturating at STARVE_LIMIT) each cycle DebugReq=1, DebugAck=0, and debug is not granted; it SHALL clear on debug grant or when DebugReq=0.
REQ-022 Forced debug SHALL take the ROM port for one cycle. Fetch does not advance that cycle, and any existing output entry obeys REQ-017.
REQ-023 Run=0 SHALL stop new fetches only; a pending output entry remains valid until consumed or flushed. PC and redirect handling still operate.

Reset
REQ-024 While sync_rst=1, the next state SHALL be PC=RESET_PC, FetchValid=0, FetchInstruction=0, FetchPC=0, DebugAck=0, DebugData=0, and counter=0. Reset overrides all other inputs.
REQ-025 Reset asserted mid-operation SHALL discard any pending fetch entry and any in-flight debug access (no DebugAck is issued for it).
REQ-026 On the first cycle after reset with Run=1, the block SHALL fetch from RESET_PC.

Verification
REQ-027 Use a ROM model with addr1=16'hB00E, addr15=16'hCD07, addr16=16'hCC0B. Reset, then Run=1, FetchReady=1 -> after the first fetch cycle FetchValid=1, FetchPC=16'h0001, FetchInstruction=16'hB00E; then PC 2,3,... one word per cycle.
REQ-028 Hold FetchReady=0 for 3 cycles with a valid entry -> Fetch* outputs stable and PC not incremented. Then release FetchReady -> the next PC entry appears the next cycle.
REQ-029 Assert RedirectValid=1 with RedirectAddress=16'h000F while FetchValid=1 -> next cycle FetchValid=0; the cycle after that FetchPC=16'h000F, FetchInstruction=16'hCD07, then FetchPC=16'h0010 with 16'hCC0B.
REQ-030 With Run=1 and FetchReady=1 continuously, assert DebugReq with DebugAddress=16'h0001 -> DebugAck is asserted exactly STARVE_LIMIT+1 cycles after DebugReq rises, with DebugData=16'hB00E; fetch skips exactly one cycle, and no PC is skipped or duplicated.
REQ-031 Run=0 with DebugReq and DebugAddress=16'h0010 -> DebugAck the next cycle with DebugData=16'hCC0B; the counter stays 0.
REQ-032 PC=16'hFFFF fetch -> FetchPC=16'hFFFF, and the next fetch is FetchPC=16'h0000. Asserting sync_rst during a pending DebugReq -> no DebugAck, and PC=RESET_PC after reset.
